operand_fetch: RTL and testbench
================================

# operand_fetch

Issue-stage reader for the processor register file. Accepts decoded instructions over a valid/ready handshake, drives the register file read addresses, and holds an instruction while a source or destination register has a pending write (scoreboard). It presents a registered operand bundle to the execute stage and snoops the write-back port to clear pending bits.

## Interface
- DATA_WIDTH, 32, operand width
- REGISTERS, 32, architectural register count; x0 hardwired zero
- LOG2_REGISTERS, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  instruction accepted this cycle when high with dec_valid
- dec_rs1, dec_rs2, dec_rd  in  LOG2_REGISTERS  source/destination indices; rd=0 means no write
- dec_uses_rs1, dec_uses_rs2  in  1  source actually read; unused sources never cause hazards
- rf_addr_rs1, rf_addr_rs2  out  LOG2_REGISTERS  register file read addresses; combinational copy of dec_rs1/dec_rs2
- rf_data_rs1, rf_data_rs2  in  DATA_WIDTH  combinational register file read data
- wb_rd  in  LOG2_REGISTERS  write-back destination this cycle; 0 = no write-back
- wb_data  in  DATA_WIDTH  write-back value
- iss_valid  out  1  operand bundle valid
- iss_ready  in  1  execute stage accepts bundle
- iss_rs1_val, iss_rs2_val  out  DATA_WIDTH  captured operands
- iss_rd  out  LOG2_REGISTERS  captured destination
- busy  out  1  OR of all scoreboard bits

## Operation
- Scoreboard: REGISTERS-bit vector `pend`; bit 0 constant 0.
- Hazard when any holds: dec_uses_rs1 and pend[dec_rs1]; dec_uses_rs2 and pend[dec_rs2]; dec_rd≠0 and pend[dec_rd] (WAW).
- Output FSM, two states:
  - EMPTY: iss_valid=0. dec_ready = !hazard.
  - FULL: iss_valid=1. dec_ready = !hazard && iss_ready.
- Accept (dec_valid && dec_ready): capture operands and dec_rd into output registers, go or stay FULL; if dec_rd≠0 set pend[dec_rd].
- FULL with iss_ready and no accept: go EMPTY.
- Write-back: wb_rd≠0 clears pend[wb_rd] at the edge.
- Same-cycle set and clear on the same index: set wins.
- Unused or x0 sources capture 0 regardless of register file data.
- Operand registers and iss_rd stay stable while FULL and iss_ready=0.
- Reset: pend=0, state EMPTY; iss_valid=0, iss_rs1_val=0, iss_rs2_val=0, iss_rd=0, busy=0. dec_ready follows from empty scoreboard (1). Reset mid-operation discards the held bundle and all pending bits immediately.

## Timing
- Latency: accept in cycle N → iss_valid in N+1.
- Throughput: one instruction per cycle with no hazards and iss_ready held high.
- Without bypass, write-back in cycle N clears the hazard from N+1; the operand is then read from the updated register file.
- dec_ready depends combinationally on dec_* and iss_ready, not on dec_valid. There is no combinational path from rf_data_* to any handshake signal.

## Configuration
- OPERAND_FETCH_BYPASS_EN defined: hazard check uses `pend` with the current-cycle wb_rd bit masked off. A source equal to wb_rd (≠0) captures wb_data instead of rf_data. A dependent instruction issues in the same cycle as its write-back.
- Undefined: no masking, no forwarding mux; one extra stall cycle per RAW dependency.

## Structure
- Shared package: DATA_WIDTH/LOG2_REGISTERS defaults, FSM state encoding (EMPTY/FULL), and the x0 index constant.
- One sub-module: `scoreboard`. It holds `pend`, handles set/clear priority, and outputs the three hazard bits. The top level holds the FSM, operand registers and the bypass mux.

## Test plan
- Reset: assert rst mid-FULL with pend[5]=1 → iss_valid=0, busy=0, dec_ready=1 without waiting for a clock edge.
- Back-to-back independent: issue rd=1, rd=2, rd=3 with iss_ready=1 → iss_valid high for three consecutive cycles, dec_ready never drops.
- RAW stall: issue rd=5; next instruction reads rs1=5. Without bypass, wb_rd=5, wb_data=0xDEADBEEF in cycle 10 → issue in cycle 11, iss_rs1_val=0xDEADBEEF. With bypass → issue in cycle 10 with the same value.
- WAW: rd=7 pending; next instruction has rd=7 and no sources → stalled until wb_rd=7; same-cycle set/clear leaves pend[7]=1.
- Backpressure: iss_ready=0 for 4 cycles while FULL → iss_* held constant, dec_ready=0, no scoreboard set.
- x0 and unused sources: rs1=0, dec_uses_rs2=0 with pend[rs2]=1 → no stall, iss_rs1_val=0, iss_rs2_val=0.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_pkg
// Purpose  : Shared definitions for the operand fetch stage. Holds the default
//            operand width and register-index sizing, the issue-slot state
//            encoding and the index of the hardwired-zero register.
// Revision : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

  localparam int c_DATA_WIDTH_DEF     = 32;
  localparam int c_REGISTERS_DEF      = 32;
  localparam int c_LOG2_REGISTERS_DEF = 5;

  // Architectural register that always reads zero and is never written.
  localparam int c_X0_IDX = 0;

  // Occupancy of the single-entry issue slot feeding the execute stage.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } of_state_e;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_scoreboard
// Purpose  : Pending-write scoreboard. One bit per architectural register is
//            set when an instruction writing it issues and cleared when the
//            write-back port retires it. Produces the three hazard flags for
//            the instruction currently presented by the decoder.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            set_en_i          - instruction accepted this cycle
//            set_idx_i         - destination of the accepted instruction
//            clr_idx_i         - write-back destination this cycle
//            clr_mask_en_i     - ignore the bit being written back this cycle
//                                when evaluating hazards (forwarding active)
//            rs1_i/rs2_i/rd_i  - decoder register indices
//            uses_rs1_i/_rs2_i - source actually read
//            haz_rs1_o/_rs2_o  - RAW hazard on each source
//            haz_rd_o          - WAW hazard on the destination
//            busy_o            - any register pending
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int REGISTERS      = c_REGISTERS_DEF,
  parameter int LOG2_REGISTERS = c_LOG2_REGISTERS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en_i,
  input  logic [LOG2_REGISTERS-1:0] set_idx_i,
  input  logic [LOG2_REGISTERS-1:0] clr_idx_i,
  input  logic                      clr_mask_en_i,
  input  logic [LOG2_REGISTERS-1:0] rs1_i,
  input  logic [LOG2_REGISTERS-1:0] rs2_i,
  input  logic [LOG2_REGISTERS-1:0] rd_i,
  input  logic                      uses_rs1_i,
  input  logic                      uses_rs2_i,
  output logic                      haz_rs1_o,
  output logic                      haz_rs2_o,
  output logic                      haz_rd_o,
  output logic                      busy_o
);

  logic [REGISTERS-1:0] r_pend_q;
  logic [REGISTERS-1:0] w_pend_d;
  logic [REGISTERS-1:0] w_pend_eff;

  // Index 0 doubles as "no write" on both the set and clear ports, so the
  // x0 bit is simply tied low and no separate enable decode is needed.
  generate
    for (genvar g = 0; g < REGISTERS; g++) begin : g_pend_bit
      if (g == c_X0_IDX) begin : g_x0
        assign w_pend_d[g]   = 1'b0;
        assign w_pend_eff[g] = 1'b0;
      end else begin : g_reg
        logic w_set;
        logic w_clr;
        assign w_set = set_en_i && (set_idx_i == LOG2_REGISTERS'(g));
        assign w_clr = (clr_idx_i == LOG2_REGISTERS'(g));
        // A retiring write and a new issue to the same register in one cycle
        // leave the register pending: the newer write is still outstanding.
        assign w_pend_d[g]   = w_set || (r_pend_q[g] && !w_clr);
        assign w_pend_eff[g] = r_pend_q[g] && !(clr_mask_en_i && w_clr);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_q <= '0;
    end else begin
      r_pend_q <= w_pend_d;
    end
  end

  assign haz_rs1_o = uses_rs1_i && w_pend_eff[rs1_i];
  assign haz_rs2_o = uses_rs2_i && w_pend_eff[rs2_i];
  assign haz_rd_o  = w_pend_eff[rd_i];
  assign busy_o    = |r_pend_q;

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Issue-stage register file reader. Accepts decoded instructions on
//            a valid/ready handshake, reads the register file, holds any
//            instruction whose sources or destination have a write in flight,
//            and presents a registered operand bundle to the execute stage.
// Macro    : OPERAND_FETCH_BYPASS_EN - when defined, a write-back in the
//            current cycle satisfies a dependent instruction immediately and
//            wb_data is forwarded in place of the register file value.
// Ports    : clk, rst                   - clock, async active-high reset
//            dec_valid/dec_ready        - decoder handshake
//            dec_rs1/dec_rs2/dec_rd     - register indices (rd=0: no write)
//            dec_uses_rs1/dec_uses_rs2  - source actually read
//            rf_addr_rs1/rf_addr_rs2    - register file read addresses
//            rf_data_rs1/rf_data_rs2    - register file read data
//            wb_rd/wb_data              - write-back port (wb_rd=0: idle)
//            iss_valid/iss_ready        - execute stage handshake
//            iss_rs1_val/iss_rs2_val    - captured operands
//            iss_rd                     - captured destination
//            busy                       - any register write pending
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH     = c_DATA_WIDTH_DEF,
  parameter int REGISTERS      = c_REGISTERS_DEF,
  parameter int LOG2_REGISTERS = c_LOG2_REGISTERS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [LOG2_REGISTERS-1:0] dec_rs1,
  input  logic [LOG2_REGISTERS-1:0] dec_rs2,
  input  logic [LOG2_REGISTERS-1:0] dec_rd,
  input  logic                      dec_uses_rs1,
  input  logic                      dec_uses_rs2,
  output logic [LOG2_REGISTERS-1:0] rf_addr_rs1,
  output logic [LOG2_REGISTERS-1:0] rf_addr_rs2,
  input  logic [DATA_WIDTH-1:0]     rf_data_rs1,
  input  logic [DATA_WIDTH-1:0]     rf_data_rs2,
  input  logic [LOG2_REGISTERS-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [DATA_WIDTH-1:0]     iss_rs1_val,
  output logic [DATA_WIDTH-1:0]     iss_rs2_val,
  output logic [LOG2_REGISTERS-1:0] iss_rd,
  output logic                      busy
);

  localparam logic [LOG2_REGISTERS-1:0] c_X0 = LOG2_REGISTERS'(c_X0_IDX);

  of_state_e                 r_state_q;
  of_state_e                 w_state_d;
  logic                      w_accept;
  logic                      w_hazard;
  logic                      w_haz_rs1;
  logic                      w_haz_rs2;
  logic                      w_haz_rd;
  logic                      w_bypass_en;
  logic [DATA_WIDTH-1:0]     w_rs1_src;
  logic [DATA_WIDTH-1:0]     w_rs2_src;
  logic [DATA_WIDTH-1:0]     w_rs1_cap;
  logic [DATA_WIDTH-1:0]     w_rs2_cap;
  logic [DATA_WIDTH-1:0]     r_rs1_val_q;
  logic [DATA_WIDTH-1:0]     w_rs1_val_d;
  logic [DATA_WIDTH-1:0]     r_rs2_val_q;
  logic [DATA_WIDTH-1:0]     w_rs2_val_d;
  logic [LOG2_REGISTERS-1:0] r_rd_q;
  logic [LOG2_REGISTERS-1:0] w_rd_d;

  // --------------------------------------------------------------------------
  // Register file read and optional write-back forwarding
  // --------------------------------------------------------------------------
  assign rf_addr_rs1 = dec_rs1;
  assign rf_addr_rs2 = dec_rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
  assign w_bypass_en = 1'b1;
  assign w_rs1_src   = ((wb_rd != c_X0) && (wb_rd == dec_rs1)) ? wb_data : rf_data_rs1;
  assign w_rs2_src   = ((wb_rd != c_X0) && (wb_rd == dec_rs2)) ? wb_data : rf_data_rs2;
`else
  // Without forwarding the write-back value only reaches the operands through
  // the register file one cycle later.
  logic w_unused_wb_data;
  assign w_bypass_en      = 1'b0;
  assign w_rs1_src        = rf_data_rs1;
  assign w_rs2_src        = rf_data_rs2;
  assign w_unused_wb_data = ^wb_data;
`endif

  // Unread sources and x0 are forced to zero so stale register file data can
  // never leak into the bundle.
  assign w_rs1_cap = (dec_uses_rs1 && (dec_rs1 != c_X0)) ? w_rs1_src : '0;
  assign w_rs2_cap = (dec_uses_rs2 && (dec_rs2 != c_X0)) ? w_rs2_src : '0;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  operand_fetch_scoreboard #(
    .REGISTERS      (REGISTERS),
    .LOG2_REGISTERS (LOG2_REGISTERS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .set_en_i      (w_accept),
    .set_idx_i     (dec_rd),
    .clr_idx_i     (wb_rd),
    .clr_mask_en_i (w_bypass_en),
    .rs1_i         (dec_rs1),
    .rs2_i         (dec_rs2),
    .rd_i          (dec_rd),
    .uses_rs1_i    (dec_uses_rs1),
    .uses_rs2_i    (dec_uses_rs2),
    .haz_rs1_o     (w_haz_rs1),
    .haz_rs2_o     (w_haz_rs2),
    .haz_rd_o      (w_haz_rd),
    .busy_o        (busy)
  );

  assign w_hazard = w_haz_rs1 || w_haz_rs2 || w_haz_rd;

  // --------------------------------------------------------------------------
  // Issue slot FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= ST_EMPTY;
    end else begin
      r_state_q <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    dec_ready = 1'b0;
    w_accept  = 1'b0;
    case (r_state_q)
      ST_EMPTY: dec_ready = !w_hazard;
      // A full slot can take a new bundle only in the cycle it drains.
      ST_FULL:  dec_ready = !w_hazard && iss_ready;
      default:  dec_ready = 1'b0;
    endcase
    w_accept = dec_valid && dec_ready;
    if (w_accept) begin
      w_state_d = ST_FULL;
    end else if ((r_state_q == ST_FULL) && iss_ready) begin
      w_state_d = ST_EMPTY;
    end
  end

  assign iss_valid = (r_state_q == ST_FULL);

  // --------------------------------------------------------------------------
  // Operand bundle registers: load only on accept, otherwise hold
  // --------------------------------------------------------------------------
  assign w_rs1_val_d = w_accept ? w_rs1_cap : r_rs1_val_q;
  assign w_rs2_val_d = w_accept ? w_rs2_cap : r_rs2_val_q;
  assign w_rd_d      = w_accept ? dec_rd    : r_rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1_val_q <= '0;
      r_rs2_val_q <= '0;
      r_rd_q      <= '0;
    end else begin
      r_rs1_val_q <= w_rs1_val_d;
      r_rs2_val_q <= w_rs2_val_d;
      r_rd_q      <= w_rd_d;
    end
  end

  assign iss_rs1_val = r_rs1_val_q;
  assign iss_rs2_val = r_rs2_val_q;
  assign iss_rd      = r_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Self-checking bench for operand_fetch. A behavioural model keeps
//            the set of registers with writes in flight, the content of the
//            issue slot and a copy of the register file; directed scenarios
//            and a randomized run are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int LR = 5;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic          dec_ready;
  logic [LR-1:0] dec_rs1, dec_rs2, dec_rd;
  logic          dec_uses_rs1, dec_uses_rs2;
  logic [LR-1:0] rf_addr_rs1, rf_addr_rs2;
  logic [DW-1:0] rf_data_rs1, rf_data_rs2;
  logic [LR-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          iss_valid;
  logic          iss_ready;
  logic [DW-1:0] iss_rs1_val, iss_rs2_val;
  logic [LR-1:0] iss_rd;
  logic          busy;

  logic [DW-1:0] tb_rf [NR];

  assign rf_data_rs1 = tb_rf[rf_addr_rs1];
  assign rf_data_rs2 = tb_rf[rf_addr_rs2];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_uses_rs1 (dec_uses_rs1),
    .dec_uses_rs2 (dec_uses_rs2),
    .rf_addr_rs1  (rf_addr_rs1),
    .rf_addr_rs2  (rf_addr_rs2),
    .rf_data_rs1  (rf_data_rs1),
    .rf_data_rs2  (rf_data_rs2),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_rs1_val  (iss_rs1_val),
    .iss_rs2_val  (iss_rs2_val),
    .iss_rd       (iss_rd),
    .busy         (busy)
  );

  int n_vec;
  int n_err;

  // ---------------- reference model ----------------
  bit [NR-1:0]   m_pend;
  bit            m_full;
  logic [DW-1:0] m_rs1, m_rs2;
  logic [LR-1:0] m_rd;

  task automatic m_reset();
    m_pend = '0;
    m_full = 1'b0;
    m_rs1  = '0;
    m_rs2  = '0;
    m_rd   = '0;
  endtask

  function automatic bit m_hazard();
    bit [NR-1:0] eff;
    eff = m_pend;
    if (BYP && wb_rd != 0) eff[wb_rd] = 1'b0;
    return (dec_uses_rs1 && eff[dec_rs1]) || (dec_uses_rs2 && eff[dec_rs2]) ||
           (dec_rd != 0 && eff[dec_rd]);
  endfunction

  function automatic bit m_ready();
    return !m_hazard() && (!m_full || iss_ready);
  endfunction

  function automatic logic [DW-1:0] m_operand(input logic [LR-1:0] idx, input logic used);
    if (!used || idx == 0) return '0;
    if (BYP && wb_rd != 0 && wb_rd == idx) return wb_data;
    return tb_rf[idx];
  endfunction

  // Advances the model by one clock using the inputs held across the edge.
  task automatic model_edge();
    bit acc;
    acc = dec_valid && m_ready();
    if (acc) begin
      m_rs1  = m_operand(dec_rs1, dec_uses_rs1);
      m_rs2  = m_operand(dec_rs2, dec_uses_rs2);
      m_rd   = dec_rd;
      m_full = 1'b1;
    end else if (m_full && iss_ready) begin
      m_full = 1'b0;
    end
    if (wb_rd != 0) begin
      m_pend[wb_rd] = 1'b0;
      tb_rf[wb_rd]  = wb_data;
    end
    if (acc && dec_rd != 0) m_pend[dec_rd] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_dec(input logic v, input logic [LR-1:0] r1, input logic [LR-1:0] r2,
                           input logic [LR-1:0] rd, input logic u1, input logic u2);
    dec_valid    = v;
    dec_rs1      = r1;
    dec_rs2      = r2;
    dec_rd       = rd;
    dec_uses_rs1 = u1;
    dec_uses_rs2 = u2;
  endtask

  task automatic drive_wb(input logic [LR-1:0] rd, input logic [DW-1:0] d);
    wb_rd   = rd;
    wb_data = d;
  endtask

  task automatic drain();
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i < NR; i++) begin
      if (m_pend[i]) begin
        drive_wb(LR'(i), $urandom());
        tick();
      end
    end
    drive_wb('0, '0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    #1;
    n_vec++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
    n_vec++; if (iss_rs1_val !== '0 || iss_rs2_val !== '0) begin n_err++; $display("FAIL reset_vals: got %h/%h want 0/0", iss_rs1_val, iss_rs2_val); end
    n_vec++; if (iss_rd !== '0) begin n_err++; $display("FAIL reset_iss_rd: got %0d want 0", iss_rd); end
    n_vec++; if (busy !== 1'b0 || dec_ready !== 1'b1) begin n_err++; $display("FAIL reset_busy_ready: got %b/%b want 0/1", busy, dec_ready); end
    // Fill the slot with a write to x5 and hold it, then reset between edges.
    iss_ready = 1'b0;
    drive_dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    drive_dec(1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    n_vec++; if (iss_valid !== 1'b1 || busy !== 1'b1 || dec_ready !== 1'b0) begin n_err++; $display("FAIL prereset_full: got v=%b busy=%b rdy=%b want 1/1/0", iss_valid, busy, dec_ready); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (iss_valid !== 1'b0 || busy !== 1'b0 || dec_ready !== 1'b1) begin n_err++; $display("FAIL async_reset: got v=%b busy=%b rdy=%b want 0/0/1", iss_valid, busy, dec_ready); end
    #1 rst = 1'b0;
    m_reset();
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    iss_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive_dec(1'b1, '0, '0, LR'(k), 1'b0, 1'b0);
      #1;
      n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 1", k, dec_ready); end
      tick();
      n_vec++; if (iss_valid !== 1'b1 || iss_rd !== LR'(k)) begin n_err++; $display("FAIL b2b_issue%0d: got v=%b rd=%0d want 1/%0d", k, iss_valid, iss_rd, k); end
    end
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    n_vec++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", iss_valid); end
    drain();
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_clear: got %b want 0", busy); end
  endtask

  task automatic test_raw();
    iss_ready = 1'b1;
    drive_dec(1'b1, '0, '0, 5'd5, 1'b0, 1'b0);
    tick();
    drive_dec(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall%0d: got %b want 0", k, dec_ready); end
      tick();
    end
    n_vec++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL raw_slot_empty: got %b want 0", iss_valid); end
    drive_wb(5'd5, 32'hDEADBEEF);
    #1;
`ifdef OPERAND_FETCH_BYPASS_EN
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL raw_wb_ready: got %b want 1", dec_ready); end
    tick();
`else
    n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL raw_wb_ready: got %b want 0", dec_ready); end
    tick();
    drive_wb('0, '0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL raw_after_wb_ready: got %b want 1", dec_ready); end
    tick();
`endif
    n_vec++; if (iss_valid !== 1'b1 || iss_rs1_val !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_operand: got v=%b val=%h want 1/deadbeef", iss_valid, iss_rs1_val); end
    drive_wb('0, '0);
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    drain();
  endtask

  task automatic test_waw();
    iss_ready = 1'b1;
    drive_dec(1'b1, '0, '0, 5'd7, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall%0d: got %b want 0", k, dec_ready); end
      tick();
    end
    drive_wb(5'd7, 32'h0000_7777);
    #1;
`ifdef OPERAND_FETCH_BYPASS_EN
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL waw_wb_ready: got %b want 1", dec_ready); end
    tick();
`else
    n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL waw_wb_ready: got %b want 0", dec_ready); end
    tick();
    drive_wb('0, '0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL waw_after_wb_ready: got %b want 1", dec_ready); end
    tick();
`endif
    n_vec++; if (iss_valid !== 1'b1 || iss_rd !== 5'd7 || busy !== 1'b1) begin n_err++; $display("FAIL waw_issue: got v=%b rd=%0d busy=%b want 1/7/1", iss_valid, iss_rd, busy); end
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    drive_wb('0, '0);
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL waw_pend_kept: got %b want 1", busy); end
    drain();
    // Issue to x7 while a (stale) write-back to x7 retires: x7 stays pending.
    drive_dec(1'b1, '0, '0, 5'd7, 1'b0, 1'b0);
    drive_wb(5'd7, 32'h0000_1234);
    tick();
    drive_wb('0, '0);
    #1;
    n_vec++; if (busy !== 1'b1 || dec_ready !== 1'b0) begin n_err++; $display("FAIL set_wins: got busy=%b rdy=%b want 1/0", busy, dec_ready); end
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    drain();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e1, e2;
    iss_ready = 1'b0;
    e1 = tb_rf[3];
    e2 = tb_rf[4];
    drive_dec(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1);
    tick();
    drive_dec(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d: got %b want 0", k, dec_ready); end
      tick();
      n_vec++; if (iss_valid !== 1'b1 || iss_rs1_val !== e1 || iss_rs2_val !== e2 || iss_rd !== 5'd9) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b %h %h rd=%0d want 1 %h %h rd=9", k, iss_valid, iss_rs1_val, iss_rs2_val, iss_rd, e1, e2);
      end
    end
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    iss_ready = 1'b1;
    tick();
    drive_wb(5'd9, 32'h0000_0009);
    tick();
    drive_wb('0, '0);
    #1;
    n_vec++; if (busy !== 1'b0 || iss_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_set: got busy=%b v=%b want 0/0", busy, iss_valid); end
  endtask

  task automatic test_x0_unused();
    iss_ready = 1'b1;
    tb_rf[0]  = 32'hA5A5_A5A5;
    tb_rf[12] = 32'h1212_1212;
    drive_dec(1'b1, '0, '0, 5'd12, 1'b0, 1'b0);
    tick();
    drive_dec(1'b1, 5'd0, 5'd12, 5'd13, 1'b1, 1'b0);
    #1;
    n_vec++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", dec_ready); end
    tick();
    n_vec++; if (iss_valid !== 1'b1 || iss_rs1_val !== '0 || iss_rs2_val !== '0 || iss_rd !== 5'd13) begin
      n_err++; $display("FAIL x0_vals: got v=%b %h %h rd=%0d want 1 0 0 rd=13", iss_valid, iss_rs1_val, iss_rs2_val, iss_rd);
    end
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_dec(1'($urandom_range(0, 1)), LR'($urandom_range(0, 7)), LR'($urandom_range(0, 7)),
                LR'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      iss_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) drive_wb(LR'($urandom_range(1, 7)), $urandom());
      else drive_wb('0, '0);
      #1;
      n_vec++; if (rf_addr_rs1 !== dec_rs1 || rf_addr_rs2 !== dec_rs2) begin n_err++; $display("FAIL rnd_rf_addr c%0d: got %0d/%0d want %0d/%0d", c, rf_addr_rs1, rf_addr_rs2, dec_rs1, dec_rs2); end
      n_vec++; if (dec_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, dec_ready, m_ready()); end
      tick();
      n_vec++; if (iss_valid !== m_full || busy !== (|m_pend)) begin n_err++; $display("FAIL rnd_state c%0d: got v=%b busy=%b want %b/%b", c, iss_valid, busy, m_full, |m_pend); end
      n_vec++; if (iss_rs1_val !== m_rs1 || iss_rs2_val !== m_rs2 || iss_rd !== m_rd) begin
        n_err++; $display("FAIL rnd_bundle c%0d: got %h %h rd=%0d want %h %h rd=%0d", c, iss_rs1_val, iss_rs2_val, iss_rd, m_rs1, m_rs2, m_rd);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < NR; i++) tb_rf[i] = $urandom();
    rst       = 1'b1;
    iss_ready = 1'b0;
    drive_dec(1'b0, '0, '0, '0, 1'b0, 1'b0);
    drive_wb('0, '0);
    m_reset();
    test_reset();
    test_back_to_back();
    test_raw();
    test_waw();
    test_backpressure();
    test_x0_unused();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
